// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU ops, stalled data-memory LOAD/STORE and jump resolution.
// Memory accesses and HALT stall upstream through r2_pc_halt; taken jumps redirect via r2_pc_flush.
module exec_stage #(
  parameter int D_SIZE = 32,
  parameter int A_SIZE = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        r1_opcode,
  input  logic [2:0]        r1_destination,
  input  logic [D_SIZE-1:0] r1_operand_a,
  input  logic [D_SIZE-1:0] r1_operand_b,
  input  logic [D_SIZE-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [A_SIZE-1:0] mem_addr,
  output logic [D_SIZE-1:0] mem_wdata,
  output logic              r2_pc_halt,
  output logic              r2_pc_flush,
  output logic [A_SIZE-1:0] r2_jump_addr,
  output logic              r2_wr_en,
  output logic [2:0]        r2_wr_dest,
  output logic [D_SIZE-1:0] r2_wr_data
);

  localparam int SH_W = (D_SIZE > 1) ? $clog2(D_SIZE) : 1;

  // Opcode 00 and every code above 0C fall through as NOP.
  localparam logic [6:0] OP_ADD   = 7'h01;
  localparam logic [6:0] OP_SUB   = 7'h02;
  localparam logic [6:0] OP_AND   = 7'h03;
  localparam logic [6:0] OP_OR    = 7'h04;
  localparam logic [6:0] OP_XOR   = 7'h05;
  localparam logic [6:0] OP_SHL   = 7'h06;
  localparam logic [6:0] OP_SHR   = 7'h07;
  localparam logic [6:0] OP_LOAD  = 7'h08;
  localparam logic [6:0] OP_STORE = 7'h09;
  localparam logic [6:0] OP_JMP   = 7'h0A;
  localparam logic [6:0] OP_JMPZ  = 7'h0B;
  localparam logic [6:0] OP_HALT  = 7'h0C;

  typedef enum logic [1:0] {
    EXEC,
    MEM_WAIT,
    HALTED
  } state_e;

  state_e              state_q, state_d;
  logic                memRd_q, memRd_d;
  logic                memWr_q, memWr_d;
  logic [A_SIZE-1:0]   memAddr_q, memAddr_d;
  logic [D_SIZE-1:0]   memWdata_q, memWdata_d;
  logic                wrEn_q, wrEn_d;
  logic [2:0]          wrDest_q, wrDest_d;
  logic [D_SIZE-1:0]   wrData_q, wrData_d;

  logic                isAlu, isLoad, isStore, isJmp, isJmpz, isHalt, jmpzTaken;
  logic [SH_W-1:0]     shAmt;
  logic [D_SIZE-1:0]   aluResult;

  always_comb begin
    isAlu     = (r1_opcode >= OP_ADD) && (r1_opcode <= OP_SHR);
    isLoad    = (r1_opcode == OP_LOAD);
    isStore   = (r1_opcode == OP_STORE);
    isJmp     = (r1_opcode == OP_JMP);
    isJmpz    = (r1_opcode == OP_JMPZ);
    isHalt    = (r1_opcode == OP_HALT);
    jmpzTaken = isJmpz && (r1_operand_a == '0);
  end

  // Only the low log2(D_SIZE) bits of operand b select the shift distance.
  always_comb begin
    shAmt     = r1_operand_b[SH_W-1:0];
    aluResult = '0;
    case (r1_opcode)
      OP_ADD:  aluResult = r1_operand_a + r1_operand_b;
      OP_SUB:  aluResult = r1_operand_a - r1_operand_b;
      OP_AND:  aluResult = r1_operand_a & r1_operand_b;
      OP_OR:   aluResult = r1_operand_a | r1_operand_b;
      OP_XOR:  aluResult = r1_operand_a ^ r1_operand_b;
      OP_SHL:  aluResult = r1_operand_a << shAmt;
      OP_SHR:  aluResult = r1_operand_a >> shAmt;
      default: aluResult = '0;
    endcase
  end

  always_comb begin
    r2_pc_halt   = 1'b0;
    r2_pc_flush  = 1'b0;
    r2_jump_addr = '0;
    case (state_q)
      EXEC: begin
        r2_pc_halt = isLoad || isStore || isHalt;
        if (isJmp) begin
          r2_pc_flush  = 1'b1;
          r2_jump_addr = r1_operand_a[A_SIZE-1:0];
        end else if (jmpzTaken) begin
          r2_pc_flush  = 1'b1;
          r2_jump_addr = r1_operand_b[A_SIZE-1:0];
        end
      end
      MEM_WAIT: r2_pc_halt = !mem_ready;
      HALTED:   r2_pc_halt = 1'b1;
      default:  r2_pc_halt = 1'b0;
    endcase
  end

  // Writeback is a one-cycle pulse; dest/data hold their last written value otherwise.
  always_comb begin
    state_d    = state_q;
    memRd_d    = memRd_q;
    memWr_d    = memWr_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    wrEn_d     = 1'b0;
    wrDest_d   = wrDest_q;
    wrData_d   = wrData_q;
    case (state_q)
      EXEC: begin
        if (isAlu) begin
          wrEn_d   = 1'b1;
          wrDest_d = r1_destination;
          wrData_d = aluResult;
        end else if (isLoad || isStore) begin
          state_d   = MEM_WAIT;
          memRd_d   = isLoad;
          memWr_d   = isStore;
          memAddr_d = r1_operand_a[A_SIZE-1:0];
          if (isStore) begin
            memWdata_d = r1_operand_b;
          end
        end else if (isHalt) begin
          state_d = HALTED;
        end
      end
      MEM_WAIT: begin
        // The instruction is held upstream while stalled, so r1_destination is still valid here.
        if (mem_ready) begin
          state_d = EXEC;
          memRd_d = 1'b0;
          memWr_d = 1'b0;
          if (memRd_q) begin
            wrEn_d   = 1'b1;
            wrDest_d = r1_destination;
            wrData_d = mem_rdata;
          end
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = EXEC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EXEC;
      memRd_q    <= 1'b0;
      memWr_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      wrEn_q     <= 1'b0;
      wrDest_q   <= '0;
      wrData_q   <= '0;
    end else begin
      state_q    <= state_d;
      memRd_q    <= memRd_d;
      memWr_q    <= memWr_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      wrEn_q     <= wrEn_d;
      wrDest_q   <= wrDest_d;
      wrData_q   <= wrData_d;
    end
  end

  assign mem_rd     = memRd_q;
  assign mem_wr     = memWr_q;
  assign mem_addr   = memAddr_q;
  assign mem_wdata  = memWdata_q;
  assign r2_wr_en   = wrEn_q;
  assign r2_wr_dest = wrDest_q;
  assign r2_wr_data = wrData_q;

endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: directed vector table, memory/halt/reset sequences,
// and random instruction streams checked against an instruction-level reference model.
module tb_exec_stage;

  localparam int D = 32;
  localparam int A = 10;

  localparam logic [6:0] OP_NOP   = 7'h00;
  localparam logic [6:0] OP_ADD   = 7'h01;
  localparam logic [6:0] OP_SUB   = 7'h02;
  localparam logic [6:0] OP_AND   = 7'h03;
  localparam logic [6:0] OP_OR    = 7'h04;
  localparam logic [6:0] OP_XOR   = 7'h05;
  localparam logic [6:0] OP_SHL   = 7'h06;
  localparam logic [6:0] OP_SHR   = 7'h07;
  localparam logic [6:0] OP_LOAD  = 7'h08;
  localparam logic [6:0] OP_STORE = 7'h09;
  localparam logic [6:0] OP_JMP   = 7'h0A;
  localparam logic [6:0] OP_JMPZ  = 7'h0B;
  localparam logic [6:0] OP_HALT  = 7'h0C;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [6:0]   r1_opcode;
  logic [2:0]   r1_destination;
  logic [D-1:0] r1_operand_a, r1_operand_b, mem_rdata;
  logic         mem_ready;
  logic         mem_rd, mem_wr, r2_pc_halt, r2_pc_flush, r2_wr_en;
  logic [A-1:0] mem_addr, r2_jump_addr;
  logic [D-1:0] mem_wdata, r2_wr_data;
  logic [2:0]   r2_wr_dest;

  int totalChecks = 0;
  int badChecks   = 0;

  typedef struct {
    logic [6:0]   op;
    logic [2:0]   dest;
    logic [D-1:0] a;
    logic [D-1:0] b;
    logic         halt;
    logic         flush;
    logic [A-1:0] jaddr;
    logic         wrEn;
    logic [D-1:0] data;
  } vec_t;

  vec_t vecs[14];

  exec_stage #(.D_SIZE(D), .A_SIZE(A)) dut (
    .clk(clk), .rst_n(rst_n),
    .r1_opcode(r1_opcode), .r1_destination(r1_destination),
    .r1_operand_a(r1_operand_a), .r1_operand_b(r1_operand_b),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .r2_pc_halt(r2_pc_halt), .r2_pc_flush(r2_pc_flush), .r2_jump_addr(r2_jump_addr),
    .r2_wr_en(r2_wr_en), .r2_wr_dest(r2_wr_dest), .r2_wr_data(r2_wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] dest,
                               input logic [D-1:0] a, input logic [D-1:0] b);
    r1_opcode      = op;
    r1_destination = dest;
    r1_operand_a   = a;
    r1_operand_b   = b;
  endtask

  // Reference model: instruction semantics in plain arithmetic.
  function automatic logic [D-1:0] refAlu(input logic [6:0] op, input logic [D-1:0] a, input logic [D-1:0] b);
    int unsigned sh;
    sh = b % D;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << sh;
      OP_SHR:  return a >> sh;
      default: return '0;
    endcase
  endfunction

  function automatic logic refWrites(input logic [6:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  function automatic logic refFlush(input logic [6:0] op, input logic [D-1:0] a);
    return (op == OP_JMP) || ((op == OP_JMPZ) && (a == 0));
  endfunction

  function automatic logic [A-1:0] refJaddr(input logic [6:0] op, input logic [D-1:0] a, input logic [D-1:0] b);
    if (op == OP_JMP) return a[A-1:0];
    if ((op == OP_JMPZ) && (a == 0)) return b[A-1:0];
    return '0;
  endfunction

  task automatic runSingle(input string tag, input logic [6:0] op, input logic [2:0] dest,
                           input logic [D-1:0] a, input logic [D-1:0] b,
                           input logic expHalt, input logic expFlush, input logic [A-1:0] expJaddr,
                           input logic expWrEn, input logic [D-1:0] expData);
    @(negedge clk);
    applyStimulus(op, dest, a, b);
    mem_ready = 1'b0;
    #1;
    checkOutput({tag, ".halt"}, 32'(r2_pc_halt), 32'(expHalt));
    checkOutput({tag, ".flush"}, 32'(r2_pc_flush), 32'(expFlush));
    checkOutput({tag, ".jaddr"}, 32'(r2_jump_addr), 32'(expJaddr));
    @(posedge clk);
    #1;
    checkOutput({tag, ".wrEn"}, 32'(r2_wr_en), 32'(expWrEn));
    if (expWrEn) begin
      checkOutput({tag, ".dest"}, 32'(r2_wr_dest), 32'(dest));
      checkOutput({tag, ".data"}, r2_wr_data, expData);
    end
  endtask

  // waits = number of MEM_WAIT cycles with mem_ready low before the ready cycle.
  task automatic runMem(input string tag, input logic [6:0] op, input logic [2:0] dest,
                        input logic [D-1:0] a, input logic [D-1:0] b,
                        input int waits, input logic [D-1:0] rdata);
    logic isLd;
    isLd = (op == OP_LOAD);
    @(negedge clk);
    applyStimulus(op, dest, a, b);
    mem_ready = 1'b0;
    #1;
    checkOutput({tag, ".haltExec"}, 32'(r2_pc_halt), 32'd1);
    checkOutput({tag, ".flushExec"}, 32'(r2_pc_flush), 32'd0);
    for (int k = 0; k <= waits; k++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, ".memRd"}, 32'(mem_rd), 32'(isLd));
      checkOutput({tag, ".memWr"}, 32'(mem_wr), 32'(!isLd));
      checkOutput({tag, ".memAddr"}, 32'(mem_addr), 32'(a[A-1:0]));
      if (!isLd) checkOutput({tag, ".memWdata"}, mem_wdata, b);
      checkOutput({tag, ".wrEnWait"}, 32'(r2_wr_en), 32'd0);
      @(negedge clk);
      mem_ready = (k == waits);
      mem_rdata = (k == waits) ? rdata : D'($urandom);
      #1;
      checkOutput({tag, ".haltWait"}, 32'(r2_pc_halt), 32'(k != waits));
      checkOutput({tag, ".flushWait"}, 32'(r2_pc_flush), 32'd0);
    end
    @(posedge clk);
    #1;
    checkOutput({tag, ".rdDone"}, 32'(mem_rd), 32'd0);
    checkOutput({tag, ".wrDone"}, 32'(mem_wr), 32'd0);
    checkOutput({tag, ".wrEnDone"}, 32'(r2_wr_en), 32'(isLd));
    if (isLd) begin
      checkOutput({tag, ".dest"}, 32'(r2_wr_dest), 32'(dest));
      checkOutput({tag, ".data"}, r2_wr_data, rdata);
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [6:0]   op;
    logic [D-1:0] a, b;
    logic [2:0]   dest;
    int           r;

    vecs[0]  = '{OP_ADD,  3'd3, 32'hFFFF_FFFF, 32'd2,         1'b0, 1'b0, 10'h000, 1'b1, 32'h0000_0001};
    vecs[1]  = '{OP_SUB,  3'd1, 32'd5,         32'd7,         1'b0, 1'b0, 10'h000, 1'b1, 32'hFFFF_FFFE};
    vecs[2]  = '{OP_AND,  3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 1'b0, 10'h000, 1'b1, 32'h00F0_00F0};
    vecs[3]  = '{OP_OR,   3'd5, 32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0, 10'h000, 1'b1, 32'h1234_5678};
    vecs[4]  = '{OP_XOR,  3'd6, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 1'b0, 10'h000, 1'b1, 32'hF0F0_0F0F};
    vecs[5]  = '{OP_SHL,  3'd7, 32'd1,         32'h0000_0024, 1'b0, 1'b0, 10'h000, 1'b1, 32'h0000_0010};
    vecs[6]  = '{OP_SHR,  3'd2, 32'h8000_0000, 32'h0000_003F, 1'b0, 1'b0, 10'h000, 1'b1, 32'h0000_0001};
    vecs[7]  = '{OP_SHL,  3'd0, 32'd3,         32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b1, 32'h0000_0003};
    vecs[8]  = '{OP_ADD,  3'd1, 32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 10'h000, 1'b1, 32'h8000_0000};
    vecs[9]  = '{OP_NOP,  3'd3, 32'd9,         32'd9,         1'b0, 1'b0, 10'h000, 1'b0, 32'h0};
    vecs[10] = '{OP_JMP,  3'd3, 32'hFFFF_F2AB, 32'd0,         1'b0, 1'b1, 10'h2AB, 1'b0, 32'h0};
    vecs[11] = '{OP_JMPZ, 3'd3, 32'd0,         32'h0000_0123, 1'b0, 1'b1, 10'h123, 1'b0, 32'h0};
    vecs[12] = '{OP_JMPZ, 3'd3, 32'd7,         32'h0000_0123, 1'b0, 1'b0, 10'h000, 1'b0, 32'h0};
    vecs[13] = '{7'h55,   3'd3, 32'd1,         32'd1,         1'b0, 1'b0, 10'h000, 1'b0, 32'h0};

    rst_n     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    applyStimulus(OP_NOP, 3'd0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.memRd", 32'(mem_rd), 32'd0);
    checkOutput("rst.memWr", 32'(mem_wr), 32'd0);
    checkOutput("rst.memAddr", 32'(mem_addr), 32'd0);
    checkOutput("rst.memWdata", mem_wdata, 32'd0);
    checkOutput("rst.wrEn", 32'(r2_wr_en), 32'd0);
    checkOutput("rst.wrDest", 32'(r2_wr_dest), 32'd0);
    checkOutput("rst.wrData", r2_wr_data, 32'd0);
    checkOutput("rst.halt", 32'(r2_pc_halt), 32'd0);
    applyStimulus(OP_JMP, 3'd0, 32'h0000_0155, '0);
    #1;
    checkOutput("rst.jmpFlush", 32'(r2_pc_flush), 32'd1);
    checkOutput("rst.jmpAddr", 32'(r2_jump_addr), 32'h155);
    @(negedge clk);
    applyStimulus(OP_NOP, 3'd0, '0, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      runSingle($sformatf("vec%0d", i), vecs[i].op, vecs[i].dest, vecs[i].a, vecs[i].b,
                vecs[i].halt, vecs[i].flush, vecs[i].jaddr, vecs[i].wrEn, vecs[i].data);
    end

    runMem("load35", OP_LOAD, 3'd2, 32'h0000_0005, 32'd0, 2, 32'h0000_CAFE);
    runMem("storeMin", OP_STORE, 3'd4, 32'h0000_03FF, 32'h1357_9BDF, 0, 32'd0);
    runSingle("afterMem", OP_ADD, 3'd6, 32'd40, 32'd2, 1'b0, 1'b0, '0, 1'b1, 32'd42);

    // STORE aborted by reset on its second MEM_WAIT cycle.
    @(negedge clk);
    applyStimulus(OP_STORE, 3'd0, 32'h0000_0155, 32'hDEAD_BEEF);
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort.memWr1", 32'(mem_wr), 32'd1);
    checkOutput("abort.wdata1", mem_wdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #2;
    checkOutput("abort.memWr2", 32'(mem_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort.memWr", 32'(mem_wr), 32'd0);
    checkOutput("abort.memAddr", 32'(mem_addr), 32'd0);
    checkOutput("abort.wdata", mem_wdata, 32'd0);
    checkOutput("abort.wrEn", 32'(r2_wr_en), 32'd0);
    checkOutput("abort.haltExec", 32'(r2_pc_halt), 32'd1);
    applyStimulus(OP_NOP, 3'd0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort.memWrAfter", 32'(mem_wr), 32'd0);
    checkOutput("abort.wrEnAfter", 32'(r2_wr_en), 32'd0);
    checkOutput("abort.haltAfter", 32'(r2_pc_halt), 32'd0);
    runSingle("abortAdd", OP_ADD, 3'd1, 32'd100, 32'd23, 1'b0, 1'b0, '0, 1'b1, 32'd123);

    // Random instruction stream against the reference model (no HALT).
    for (int n = 0; n < 200; n++) begin
      r    = $urandom_range(0, 12);
      op   = (r == 12) ? 7'($urandom_range(13, 127)) : 7'(r);
      a    = D'($urandom);
      b    = D'($urandom);
      dest = 3'($urandom_range(0, 7));
      if ((op == OP_JMPZ) && ($urandom_range(0, 1) == 0)) a = '0;
      if ((op == OP_LOAD) || (op == OP_STORE)) begin
        runMem($sformatf("rnd%0d", n), op, dest, a, b, $urandom_range(0, 3), D'($urandom));
      end else begin
        runSingle($sformatf("rnd%0d", n), op, dest, a, b, 1'b0, refFlush(op, a),
                  refJaddr(op, a, b), refWrites(op), refAlu(op, a, b));
      end
    end

    // HALT is sticky until reset.
    @(negedge clk);
    applyStimulus(OP_HALT, 3'd0, '0, '0);
    #1;
    checkOutput("halt.haltExec", 32'(r2_pc_halt), 32'd1);
    checkOutput("halt.flushExec", 32'(r2_pc_flush), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("halt.wrEn", 32'(r2_wr_en), 32'd0);
      checkOutput("halt.memRd", 32'(mem_rd), 32'd0);
      checkOutput("halt.memWr", 32'(mem_wr), 32'd0);
      @(negedge clk);
      case (i)
        0:       applyStimulus(OP_ADD, 3'd1, 32'd1, 32'd1);
        1:       applyStimulus(OP_JMP, 3'd1, 32'd7, 32'd0);
        2:       applyStimulus(OP_LOAD, 3'd1, 32'd7, 32'd0);
        default: applyStimulus(OP_JMPZ, 3'd1, 32'd0, 32'd9);
      endcase
      #1;
      checkOutput("halt.haltHeld", 32'(r2_pc_halt), 32'd1);
      checkOutput("halt.flushHeld", 32'(r2_pc_flush), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(OP_ADD, 3'd5, 32'd10, 32'd20);
    #1;
    checkOutput("halt.haltRst", 32'(r2_pc_halt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("halt.resumeWrEn", 32'(r2_wr_en), 32'd1);
    checkOutput("halt.resumeDest", 32'(r2_wr_dest), 32'd5);
    checkOutput("halt.resumeData", r2_wr_data, 32'd30);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameters SHALL be: D_SIZE, default 32, data width; A_SIZE, default 10, memory and jump address width.
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 r1_opcode  input  7  opcode from the read/execute pipeline register.
REQ-005 r1_destination  input  3  destination register index.
REQ-006 r1_operand_a / r1_operand_b  input  D_SIZE each  operands.
REQ-007 mem_rdata  input  D_SIZE  data memory read data; mem_ready  input  1  memory access complete.
REQ-008 mem_rd / mem_wr  output  1 each  registered memory strobes.
REQ-009 mem_addr  output  A_SIZE  registered address; mem_wdata  output  D_SIZE  registered store data.
REQ-010 r2_pc_halt  output  1  combinational, stalls the program counter and the pipeline register.
REQ-011 r2_pc_flush  output  1  combinational, taken jump; the pipeline register loads NOP.
REQ-012 r2_jump_addr  output  A_SIZE  combinational jump target.
REQ-013 r2_wr_en  output  1;  r2_wr_dest  output  3;  r2_wr_data  output  D_SIZE  registered writeback.

Function
REQ-014 Opcode encodings SHALL be: 00 NOP, 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR, 06 SHL, 07 SHR (logical), 08 LOAD, 09 STORE, 0A JMP, 0B JMPZ, 0C HALT (hex); all other codes execute as NOP.
REQ-015 The FSM SHALL have states EXEC, MEM_WAIT, HALTED; the reset state is EXEC.
REQ-016 ALU ops in EXEC: one cycle later r2_wr_en=1, r2_wr_dest=r1_destination, r2_wr_data=result; result is a op b, modulo 2^D_SIZE.
REQ-017 SHL/SHR shift amount SHALL be operand_b[$clog2(D_SIZE)-1:0]; upper bits ignored.
REQ-018 NOP, STORE, JMP, JMPZ, HALT and undefined opcodes SHALL produce r2_wr_en=0 on the following cycle.
REQ-019 LOAD/STORE in EXEC: r2_pc_halt=1 that cycle; next edge: state MEM_WAIT, mem_rd (LOAD) or mem_wr (STORE)=1, mem_addr=operand_a[A_SIZE-1:0], mem_wdata=operand_b (STORE).
REQ-020 In MEM_WAIT: strobe and address held; r2_pc_halt = !mem_ready.
REQ-021 In MEM_WAIT with mem_ready=1: r2_pc_halt=0; next edge: strobes clear, state EXEC; LOAD also writes back r2_wr_dest=r1_destination, r2_wr_data=mem_rdata (value sampled while mem_ready=1).
REQ-022 Minimum LOAD/STORE occupancy SHALL be 2 cycles (mem_ready=1 on first MEM_WAIT cycle); there is no upper bound.
REQ-023 JMP in EXEC: r2_pc_flush=1, r2_jump_addr=operand_a[A_SIZE-1:0], for exactly that cycle.
REQ-024 JMPZ in EXEC: when operand_a==0, r2_pc_flush=1 and r2_jump_addr=operand_b[A_SIZE-1:0]; otherwise r2_pc_flush=0.
REQ-025 r2_jump_addr SHALL be 0 whenever r2_pc_flush=0.
REQ-026 HALT in EXEC: r2_pc_halt=1 that cycle; next edge: state HALTED.
REQ-027 HALTED SHALL be sticky: r2_pc_halt=1, no writeback, no strobes, r2_pc_flush=0; exit only via reset.
REQ-028 r2_pc_flush SHALL be 0 in MEM_WAIT and HALTED; r2_pc_halt and r2_pc_flush never both 1.
REQ-029 The instruction presented while r2_pc_halt=1 is held stable by the upstream stage; the block SHALL execute it exactly once.

Reset
REQ-030 rst_n=0 SHALL force immediately: state EXEC, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0, r2_wr_en=0, r2_wr_dest=0, r2_wr_data=0.
REQ-031 Reset during MEM_WAIT SHALL abort the access with no writeback; reset in HALTED SHALL resume execution.
REQ-032 During reset, combinational outputs SHALL decode as state EXEC with the current inputs.

Verification
REQ-033 ADD a=0xFFFFFFFF, b=2, dest=3 -> next cycle r2_wr_en=1, r2_wr_dest=3, r2_wr_data=0x00000001.
REQ-034 SHL a=1, b=0x00000024 -> r2_wr_data=0x00000010 (shift amount 4).
REQ-035 LOAD a=0x5, dest=2; mem_ready after 3 MEM_WAIT cycles with mem_rdata=0xCAFE -> mem_rd=1 and mem_addr=5 for 3 cycles; r2_pc_halt=1 for 3 cycles; then r2_wr_data=0xCAFE, dest 2.
REQ-036 JMPZ a=0, b=0x123 -> r2_pc_flush=1, r2_jump_addr=0x123 for one cycle; JMPZ a=7 -> no flush.
REQ-037 HALT then any opcode -> r2_pc_halt stays 1 indefinitely; rst_n pulse -> r2_pc_halt=0 and the next ADD executes.
REQ-038 STORE in flight, rst_n asserted on the second MEM_WAIT cycle -> mem_wr=0 immediately, state EXEC, r2_wr_en=0.
